// File: rtl/rf_crc_pkg.sv
// rf_crc_pkg: shared definitions for the RF CRC-16/X-25 framer.
//   state_t     - framer FSM states
//   mode_t      - frame direction, sampled on the first accepted byte
//   CRC_*       - CRC-16/X-25 constants (reflected polynomial, init, good residue)
//   RX_MIN_LEN  - shortest legal RX frame (one payload byte plus two CRC bytes)
package rf_crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_CRC_LO = 3'd2,
    ST_CRC_HI = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    MODE_TX = 1'b0,
    MODE_RX = 1'b1
  } mode_t;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
  // Engine value left after a frame plus its own (inverted, LSB-first) CRC.
  localparam logic [15:0] CRC_RESIDUE   = 16'hF0B8;
  localparam int          RX_MIN_LEN    = 3;

endpackage

// File: rtl/rf_crc_framer_if.sv
// rf_crc_framer_if: byte-stream handshake bundle around the framer.
//   s_*  - input byte stream from the RF packet buffer (valid/ready/data/last)
//   m_*  - output byte stream towards the RF serializer (valid/ready/data/last)
// Modports:
//   master - environment side: drives the input stream, consumes the output stream
//   slave  - framer side: consumes the input stream, drives the output stream
interface rf_crc_framer_if;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] s_data_i;
  logic       s_last_i;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [7:0] m_data_o;
  logic       m_last_o;

  modport master (
    output s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/crc16_x25_step.sv
// crc16_x25_step: combinational one-byte update of a reflected CRC-16/X-25
// register (poly 0x8408), unrolled bitwise, no lookup table.
//   crc      in  16  current engine value
//   data     in   8  byte to absorb
//   crc_next out 16  engine value after absorbing data
module crc16_x25_step
  import rf_crc_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  always_comb begin
    // NOTE: blocking assignments here chain the eight shift stages within one
    // evaluation; each stage reads the value the previous line just produced.
    crc_next = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY_REFL) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/rf_crc_framer.sv
// rf_crc_framer: sequences a CRC-16/X-25 byte engine between the RF packet
// buffer and the RF serializer/deserializer.
//   TX: forwards payload, then appends ~crc LSB first (last flag on the MSB byte).
//   RX: forwards payload plus received CRC, checks the engine residue.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   mode_i              0=TX, 1=RX; sampled on the first accepted byte
//   abort_i             synchronous frame abort
//   bus (slave)         s_* input stream, m_* output stream
//   busy_o              frame in progress
//   done_o              one-cycle completion pulse
//   crc_o, crc_ok_o, err_o  frame status, valid with done_o and held afterwards
// Optional feature (macro RF_CRC_STATS_EN):
//   stats_clr_i, good_cnt_o, bad_cnt_o  saturating good/bad frame counters
module rf_crc_framer
  import rf_crc_pkg::*;
#(
  parameter int MAX_LEN = 255,
  parameter int LEN_W   = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mode_i,
  input  logic        abort_i,
  rf_crc_framer_if.slave bus,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] crc_o,
  output logic        crc_ok_o,
  output logic        err_o
`ifdef RF_CRC_STATS_EN
  ,
  input  logic        stats_clr_i,
  output logic [15:0] good_cnt_o,
  output logic [15:0] bad_cnt_o
`endif
);

  state_t            state;
  mode_t             mode_q;
  mode_t             frame_mode;
  logic [15:0]       engine;
  logic [15:0]       engine_step;
  logic [15:0]       engine_next;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  count_next;
  logic              accept;
  logic              engine_en;
  logic              finish;
  logic              fin_err;
  logic              fin_ok;

  crc16_x25_step u_step (
    .crc      (engine),
    .data     (bus.s_data_i),
    .crc_next (engine_step)
  );

  // In IDLE the frame has not started yet, so the live mode input decides
  // how the first byte is treated.
  assign frame_mode = (state == ST_IDLE) ? mode_t'(mode_i) : mode_q;

  assign accept    = bus.s_valid_i & bus.m_ready_i &
                     ((state == ST_IDLE) | (state == ST_DATA));
  // A beat taken during abort still handshakes but must not touch the CRC.
  assign engine_en = accept & ~abort_i;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    bus.s_ready_o = 1'b0;
    bus.m_valid_o = 1'b0;
    bus.m_data_o  = 8'h00;
    bus.m_last_o  = 1'b0;
    case (state)
      ST_IDLE, ST_DATA: begin
        bus.m_valid_o = bus.s_valid_i;
        bus.s_ready_o = bus.m_ready_i;
        bus.m_data_o  = bus.s_data_i;
        bus.m_last_o  = bus.s_valid_i & bus.s_last_i & (frame_mode == MODE_RX);
      end
      ST_CRC_LO: begin
        bus.m_valid_o = 1'b1;
        bus.m_data_o  = ~engine[7:0];
      end
      ST_CRC_HI: begin
        bus.m_valid_o = 1'b1;
        bus.m_data_o  = ~engine[15:8];
        bus.m_last_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    engine_next = engine;
    count_next  = count;
    if (engine_en) begin
      engine_next = engine_step;
      count_next  = (count == {LEN_W{1'b1}}) ? count : count + 1'b1;
    end
  end

  // Frame completes on the last RX beat or on the CRC_HI handshake; status
  // is computed from the post-update engine/counter so it lands with done_o.
  assign finish  = (accept & bus.s_last_i & (frame_mode == MODE_RX)) |
                   ((state == ST_CRC_HI) & bus.m_ready_i);
  assign fin_err = (count_next > LEN_W'(MAX_LEN)) |
                   ((frame_mode == MODE_RX) & (count_next < LEN_W'(RX_MIN_LEN)));
  assign fin_ok  = (frame_mode == MODE_RX) & (engine_next == CRC_RESIDUE) & ~fin_err;

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_TX;
      engine   <= CRC_INIT;
      count    <= '0;
      done_o   <= 1'b0;
      crc_o    <= 16'h0000;
      crc_ok_o <= 1'b0;
      err_o    <= 1'b0;
    end else if (abort_i) begin
      state  <= ST_IDLE;
      engine <= CRC_INIT;
      count  <= '0;
      done_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; a later assignment in this block (the
      // DONE reload) overrides the default update below within the same edge.
      done_o <= 1'b0;
      engine <= engine_next;
      count  <= count_next;
      if ((state == ST_IDLE) && accept) begin
        mode_q <= frame_mode;
      end
      if (finish) begin
        state    <= ST_DONE;
        done_o   <= 1'b1;
        crc_o    <= ~engine_next;
        crc_ok_o <= fin_ok;
        err_o    <= fin_err;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state <= bus.s_last_i ? ST_CRC_LO : ST_DATA;
            end
          end
          ST_DATA: begin
            if (accept && bus.s_last_i) begin
              state <= ST_CRC_LO;
            end
          end
          ST_CRC_LO: begin
            if (bus.m_ready_i) begin
              state <= ST_CRC_HI;
            end
          end
          ST_DONE: begin
            engine <= CRC_INIT;
            count  <= '0;
            state  <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RF_CRC_STATS_EN
  logic frame_good;
  assign frame_good = ((mode_q == MODE_TX) & ~err_o) | crc_ok_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      good_cnt_o <= 16'h0000;
      bad_cnt_o  <= 16'h0000;
    end else if (stats_clr_i) begin
      good_cnt_o <= 16'h0000;
      bad_cnt_o  <= 16'h0000;
    end else if (done_o) begin
      if (frame_good) begin
        if (good_cnt_o != 16'hFFFF) good_cnt_o <= good_cnt_o + 16'h0001;
      end else begin
        if (bad_cnt_o != 16'hFFFF) bad_cnt_o <= bad_cnt_o + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_crc_framer.sv
// tb_rf_crc_framer: directed self-checking bench for rf_crc_framer.
// Expected CRC values are the hand-computed CRC-16/X-25 results for the
// "123456789" check string and its variants.
module tb_rf_crc_framer;
  import rf_crc_pkg::*;

  localparam int MAX_LEN = 255;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] crc;
  logic        crc_ok;
  logic        err;
`ifdef RF_CRC_STATS_EN
  logic        stats_clr;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  rf_crc_framer_if bus ();

  rf_crc_framer #(.MAX_LEN(MAX_LEN), .LEN_W(12)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .mode_i   (mode),
    .abort_i  (abort),
    .bus      (bus.slave),
    .busy_o   (busy),
    .done_o   (done),
    .crc_o    (crc),
    .crc_ok_o (crc_ok),
    .err_o    (err)
`ifdef RF_CRC_STATS_EN
    ,
    .stats_clr_i (stats_clr),
    .good_cnt_o  (good_cnt),
    .bad_cnt_o   (bad_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_data[$];
  logic       out_last[$];
  logic       done_seen;
  logic [15:0] cap_crc;
  logic        cap_ok;
  logic        cap_err;
  int          done_cyc;
  int          last_hs_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 8'h00;
    bus.s_last_i  = 1'b0;
    bus.m_ready_i = 1'b1;
    abort         = 1'b0;
  endtask

  task automatic load_check_string();
    in_q.delete();
    for (int i = 0; i < 9; i++) in_q.push_back(8'h31 + 8'(i));
  endtask

  // Drives in_q as one frame, collects every output handshake and the status
  // captured while done_o is high. Bounded by budget cycles.
  task automatic run_frame(input logic rx, input bit toggle, input int budget);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    out_data.delete();
    out_last.delete();
    done_seen   = 1'b0;
    done_cyc    = -1;
    last_hs_cyc = -1;
    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      mode          = rx;
      bus.m_ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.s_valid_i = (idx < in_q.size());
      bus.s_data_i  = (idx < in_q.size()) ? in_q[idx] : 8'h00;
      bus.s_last_i  = (idx == in_q.size() - 1);
      #1;
      if (bus.m_valid_o && bus.m_ready_i) begin
        out_data.push_back(bus.m_data_o);
        out_last.push_back(bus.m_last_o);
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        cap_crc   = crc;
        cap_ok    = crc_ok;
        cap_err   = err;
      end
      if (bus.s_valid_i && bus.s_ready_o) idx++;
      cyc++;
    end
    check("frame_done_seen", done_seen, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  task automatic check_stream(input string tag);
    check($sformatf("%s_len", tag), out_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_data.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), out_data[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), out_last[i], (i == exp_q.size() - 1));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    busy,          1'b0);
    check({tag, "_done"},    done,          1'b0);
    check({tag, "_crc"},     crc,           16'h0000);
    check({tag, "_ok"},      crc_ok,        1'b0);
    check({tag, "_err"},     err,           1'b0);
    check({tag, "_m_valid"}, bus.m_valid_o, 1'b0);
    check({tag, "_m_last"},  bus.m_last_o,  1'b0);
  endtask

  initial begin
    logic        seen;
    logic [15:0] held_crc;

    rst  = 1'b0;
    mode = 1'b0;
    idle_inputs();
    bus.m_ready_i = 1'b0;
`ifdef RF_CRC_STATS_EN
    stats_clr = 1'b0;
`endif
    #1 rst = 1'b1;
    #7;
    check_reset_values("reset");
    check("reset_s_ready", bus.s_ready_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // TX "123456789": payload then 0x6E, 0x90; done one cycle after 0x90.
    load_check_string();
    run_frame(1'b0, 1'b0, 100);
    exp_q = in_q;
    exp_q.push_back(8'h6E);
    exp_q.push_back(8'h90);
    check_stream("tx");
    check("tx_crc", cap_crc, 16'h906E);
    check("tx_err", cap_err, 1'b0);
    check("tx_ok",  cap_ok,  1'b0);
    check("tx_done_latency", done_cyc, last_hs_cyc + 1);
    check("tx_crc_held", crc, 16'h906E);

    // RX good frame: residue matches, crc_o = ~0xF0B8.
    load_check_string();
    in_q.push_back(8'h6E);
    in_q.push_back(8'h90);
    run_frame(1'b1, 1'b0, 100);
    exp_q = in_q;
    check_stream("rx_good");
    check("rx_good_ok",  cap_ok,  1'b1);
    check("rx_good_err", cap_err, 1'b0);
    check("rx_good_crc", cap_crc, 16'h0F47);

    // RX with corrupted last CRC byte: bit0 flip shifts the engine by 0x1189.
    in_q[10] = 8'h91;
    run_frame(1'b1, 1'b0, 100);
    check("rx_bad_ok",  cap_ok,  1'b0);
    check("rx_bad_err", cap_err, 1'b0);
    check("rx_bad_crc", cap_crc, 16'h1ECE);

    // TX with m_ready toggling every cycle, including the CRC states.
    load_check_string();
    run_frame(1'b0, 1'b1, 200);
    exp_q = in_q;
    exp_q.push_back(8'h6E);
    exp_q.push_back(8'h90);
    check_stream("tx_toggle");
    check("tx_toggle_crc", cap_crc, 16'h906E);
    check("tx_toggle_done_latency", done_cyc, last_hs_cyc + 1);

    // RX single byte: short frame error.
    in_q.delete();
    in_q.push_back(8'hAA);
    run_frame(1'b1, 1'b0, 20);
    exp_q = in_q;
    check_stream("rx_short");
    check("rx_short_err", cap_err, 1'b1);
    check("rx_short_ok",  cap_ok,  1'b0);

    // TX of MAX_LEN+1 bytes: overrun flagged, CRC still appended.
    in_q.delete();
    for (int i = 0; i < MAX_LEN + 1; i++) in_q.push_back(8'(i));
    run_frame(1'b0, 1'b0, 400);
    check("tx_long_len", out_data.size(), MAX_LEN + 3);
    if (out_data.size() == MAX_LEN + 3) begin
      check("tx_long_last_flag", out_last[MAX_LEN + 2], 1'b1);
      check("tx_long_crc_lo", out_data[MAX_LEN + 1], cap_crc[7:0]);
      check("tx_long_crc_hi", out_data[MAX_LEN + 2], cap_crc[15:8]);
      check("tx_long_payload_last", out_last[MAX_LEN], 1'b0);
    end
    check("tx_long_err", cap_err, 1'b1);
    held_crc = cap_crc;

    // Abort after 4 TX bytes: no done, held status untouched.
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mode          = 1'b0;
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 8'h31 + 8'(i);
      bus.s_last_i  = 1'b0;
      bus.m_ready_i = 1'b1;
      abort         = (i == 4);
      #1;
      if (done) seen = 1'b1;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    check("abort_idle", busy, 1'b0);
    check("abort_crc_held", crc, held_crc);
    check("abort_err_held", err, 1'b1);

    load_check_string();
    run_frame(1'b0, 1'b0, 100);
    check("after_abort_crc", cap_crc, 16'h906E);
    check("after_abort_err", cap_err, 1'b0);

    // Async reset while sitting in CRC_LO.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mode          = 1'b0;
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 8'h31 + 8'(i);
      bus.s_last_i  = (i == 8);
      bus.m_ready_i = 1'b1;
    end
    @(negedge clk);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 8'h55;
    bus.s_last_i  = 1'b0;
    bus.m_ready_i = 1'b0;
    #1;
    check("crc_lo_valid",   bus.m_valid_o, 1'b1);
    check("crc_lo_data",    bus.m_data_o,  8'h6E);
    check("crc_lo_s_ready", bus.s_ready_o, 1'b0);
    check("crc_lo_last",    bus.m_last_o,  1'b0);
    check("crc_lo_busy",    busy,          1'b1);
    rst = 1'b1;
    bus.s_valid_i = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    load_check_string();
    run_frame(1'b0, 1'b0, 100);
    check("after_reset_crc", cap_crc, 16'h906E);
    check("after_reset_err", cap_err, 1'b0);

`ifdef RF_CRC_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    check("stats_pre_good", good_cnt, 16'd0);
    check("stats_pre_bad",  bad_cnt,  16'd0);
    load_check_string();
    in_q.push_back(8'h6E);
    in_q.push_back(8'h90);
    run_frame(1'b1, 1'b0, 100);
    in_q[10] = 8'h91;
    run_frame(1'b1, 1'b0, 100);
    check("stats_good", good_cnt, 16'd1);
    check("stats_bad",  bad_cnt,  16'd1);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    check("stats_clr_good", good_cnt, 16'd0);
    check("stats_clr_bad",  bad_cnt,  16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_crc_framer.md
Name: rf_crc_framer

Overview:
Byte-stream controller that sequences a CRC-16/X-25 byte engine for the RF interface: reflected poly 0x8408, init 0xFFFF, output inverted, one byte per cycle. In TX mode it forwards payload and appends the two CRC bytes, LSB first. In RX mode it forwards payload plus received CRC and checks the residue. It sits between the RF packet buffer and the RF serializer/deserializer.

Parameters:
MAX_LEN, 255, maximum bytes per frame, including CRC bytes in RX; exceeding it flags err_o
LEN_W, 12, byte-counter width; must satisfy 2**LEN_W > MAX_LEN+2

Ports:
clk_i  in  1  clock
rst_i  in  1  async active-high reset
mode_i  in  1  0=TX append, 1=RX check; sampled on the first accepted byte of a frame
abort_i  in  1  synchronous frame abort
s_valid_i  in  1  input byte valid
s_ready_o  out  1  input ready
s_data_i  in  8  input byte
s_last_i  in  1  last input byte of frame
m_valid_o  out  1  output byte valid
m_ready_i  in  1  output ready
m_data_o  out  8  output byte
m_last_o  out  1  last output byte of frame
busy_o  out  1  frame in progress (state != IDLE)
done_o  out  1  one-cycle completion pulse
crc_o  out  16  final inverted CRC, held from done_o until the next frame start
crc_ok_o  out  1  RX residue match, valid with done_o, held
err_o  out  1  length or short-frame error, valid with done_o, held

Behaviour:
- Reset: state=IDLE, engine=0xFFFF, counter=0, crc_o=0, crc_ok_o=0, err_o=0, done_o=0. Combinational outputs evaluate to 0 in IDLE with s_valid_i=0.
- States: IDLE, DATA, CRC_LO, CRC_HI, DONE.
- IDLE/DATA pass-through, zero latency:
  - m_valid_o=s_valid_i, s_ready_o=m_ready_i, m_data_o=s_data_i.
  - A beat is accepted when s_valid_i & m_ready_i. Each accepted beat clocks the engine and increments the counter (saturating).
- IDLE: first accepted beat latches mode_i and goes to DATA. If s_last_i is also set, go straight to the end transition below.
- End transition:
  - TX: accepted beat with s_last_i goes to CRC_LO. m_last_o=0 on all payload beats.
  - RX: m_last_o=s_last_i; accepted last beat goes to DONE.
- CRC_LO: s_ready_o=0, m_valid_o=1, m_data_o=~engine[7:0], m_last_o=0. Advances on m_ready_i.
- CRC_HI: m_data_o=~engine[15:8], m_last_o=1. Advances to DONE on m_ready_i. The engine is not clocked in CRC_LO or CRC_HI.
- DONE, one cycle:
  - done_o=1 (registered).
  - crc_o=~engine.
  - crc_ok_o = RX & (engine==16'hF0B8) & !err. Always 0 in TX.
  - err_o = (count>MAX_LEN) | (RX & count<3).
  - Then synchronously reload the engine to 0xFFFF, clear the counter, go to IDLE. s_ready_o=0 in DONE.
- Length overrun does not truncate the frame; it completes at s_last_i with err_o=1.
- abort_i, any state: next cycle IDLE, engine 0xFFFF, counter 0. No done_o, no CRC bytes emitted. Held status outputs are unchanged. In the cycle where abort_i is high, the beat still handshakes if both sides are ready, but it does not clock the engine.
- abort_i has priority over a simultaneous last beat or CRC handshake.
- Async reset mid-frame: immediate return to reset values. A partial frame is dropped silently.

Optional Feature:
RF_CRC_STATS_EN
- Defined: adds outputs good_cnt_o[15:0] and bad_cnt_o[15:0], plus input stats_clr_i.
  - good_cnt_o increments on done_o with (TX & !err) or crc_ok_o.
  - bad_cnt_o increments on any other done_o.
  - Both counters saturate at 0xFFFF.
  - stats_clr_i clears both; a clear wins over a same-cycle increment.
  - Both reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rf_crc_pkg:
  - state enum encodings;
  - CRC_INIT=16'hFFFF, CRC_POLY_REFL=16'h8408, CRC_RESIDUE=16'hF0B8;
  - RX_MIN_LEN=3.
- Sub-module crc16_x25_step: combinational next-CRC from (crc_reg, byte), table-free XOR network.
  - The 16-bit engine register, with clear and enable, lives in rf_crc_framer.

Test Plan:
- TX "123456789" (0x31..0x39), m_ready_i=1 → output = the 9 bytes, then 0x6E, 0x90 with m_last_o on 0x90; crc_o=0x906E, done_o one cycle after the 0x90 handshake, err_o=0.
- RX "123456789",0x6E,0x90 → crc_ok_o=1, err_o=0, crc_o=0x0F47. Same frame with last byte 0x91 → crc_ok_o=0.
- TX with m_ready_i toggling 1/0 every cycle, including during CRC_LO/CRC_HI → byte sequence and crc_o identical to the first test; no duplicated or dropped bytes.
- RX single byte 0xAA with s_last_i → done_o, err_o=1, crc_ok_o=0. TX of MAX_LEN+1 bytes → err_o=1 and the CRC is still appended.
- abort_i asserted after 4 TX bytes, then a fresh "123456789" frame → no done_o for the aborted frame; second frame gives crc_o=0x906E.
- rst_i pulsed mid-CRC_LO → all outputs at reset values; next frame correct. With RF_CRC_STATS_EN: one good and one bad RX frame give good=1, bad=1; stats_clr_i gives 0/0.
